// File: rtl/buzdec_pkg.sv
// Shared types and default thresholds for the buzzer readback decoder.
package buzdec_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_SOLID  = 2'b01,
        ST_PULSED = 2'b10
    } buz_state_e;

    localparam int unsigned NCH_DEF        = 8;
    localparam int unsigned CNT_W_DEF      = 8;
    localparam int unsigned SILENT_CYC_DEF = 32;
    localparam int unsigned SOLID_CYC_DEF  = 32;

endpackage

// File: rtl/buzzer_chan_decoder.sv
// Single-channel decoder: classifies one buzzer line as OFF / SOLID / PULSED
// and tracks its last high run and full period.
module buzzer_chan_decoder
    import buzdec_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned SILENT_CYC = SILENT_CYC_DEF,
    parameter int unsigned SOLID_CYC  = SOLID_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             buz,
    output buz_state_e       state,
    output logic             chg_flag,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] SILENT_T = CNT_W'(SILENT_CYC);
    localparam logic [CNT_W-1:0] SOLID_T  = CNT_W'(SOLID_CYC);

    logic             s_q;
    logic [CNT_W-1:0] run_cnt;
    logic             short_high;

    logic             edge_c;
    logic             full_cyc_c;
    logic             to_off_c;
    logic             to_solid_c;
    logic [CNT_W:0]   sum_c;
    logic [CNT_W-1:0] period_sat_c;
    buz_state_e       state_d;

    // Edge/timeout detection and next classification.
    always_comb begin
        edge_c       = (buz != s_q);
        full_cyc_c   = edge_c && !s_q && short_high && (run_cnt < SILENT_T);
        to_off_c     = !edge_c && !s_q && (run_cnt == SILENT_T);
        to_solid_c   = !edge_c &&  s_q && (run_cnt == SOLID_T);
        sum_c        = {1'b0, high_len} + {1'b0, run_cnt};
        period_sat_c = sum_c[CNT_W] ? CNT_MAX : sum_c[CNT_W-1:0];
        state_d      = state;
        if (full_cyc_c) begin
            state_d = ST_PULSED;
        end else if (to_off_c) begin
            state_d = ST_OFF;
        end else if (to_solid_c) begin
            state_d = ST_SOLID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= 1'b0;
            run_cnt    <= '0;
            short_high <= 1'b0;
            state      <= ST_OFF;
            chg_flag   <= 1'b0;
            high_len   <= '0;
            period     <= '0;
        end else if (ena) begin
            s_q      <= buz;
            state    <= state_d;
            chg_flag <= (state_d != state);
            if (edge_c) begin
                run_cnt <= CNT_W'(1);
                if (s_q) begin
                    high_len   <= run_cnt;
                    short_high <= (run_cnt < SOLID_T);
                end
                if (full_cyc_c) begin
                    period <= period_sat_c;
                end
            end else begin
                if (run_cnt != CNT_MAX) begin
                    run_cnt <= run_cnt + CNT_W'(1);
                end
                if (to_off_c || to_solid_c) begin
                    short_high <= 1'b0;
                end
            end
        end else begin
            chg_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/buzzer_pattern_decoder.sv
// Multi-channel buzzer readback: per-channel decoders, change pulse and
// selected-channel timing readback.
module buzzer_pattern_decoder
    import buzdec_pkg::*;
#(
    parameter int unsigned NCH        = NCH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned SILENT_CYC = SILENT_CYC_DEF,
    parameter int unsigned SOLID_CYC  = SOLID_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [NCH-1:0]           buz_in,
    input  logic [$clog2(NCH)-1:0]   sel,
    output logic [2*NCH-1:0]         status,
    output logic                     chg,
    output logic [CNT_W-1:0]         high_out,
    output logic [CNT_W-1:0]         period_out
);

    buz_state_e       chan_state  [NCH];
    logic [CNT_W-1:0] chan_high   [NCH];
    logic [CNT_W-1:0] chan_period [NCH];
    logic [NCH-1:0]   chan_chg;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        buzzer_chan_decoder #(
            .CNT_W      (CNT_W),
            .SILENT_CYC (SILENT_CYC),
            .SOLID_CYC  (SOLID_CYC)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .buz      (buz_in[i]),
            .state    (chan_state[i]),
            .chg_flag (chan_chg[i]),
            .high_len (chan_high[i]),
            .period   (chan_period[i])
        );
        assign status[2*i +: 2] = chan_state[i];
    end

    // One pulse per cycle no matter how many channels changed together.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg <= 1'b0;
        end else begin
            chg <= ena && (|chan_chg);
        end
    end

    assign high_out   = chan_high[sel];
    assign period_out = chan_period[sel];

endmodule

// File: tb/tb_buzzer_pattern_decoder.sv
// Directed bench for buzzer_pattern_decoder: idle, solid, pulsed, multi-channel,
// enable freeze and mid-pattern reset.
module tb_buzzer_pattern_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [7:0]  buz_in;
    logic [2:0]  sel;
    logic [15:0] status;
    logic        chg;
    logic [7:0]  high_out;
    logic [7:0]  period_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int chg_cnt   = 0;
    int chg_mark  = 0;

    buzzer_pattern_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .buz_in     (buz_in),
        .sel        (sel),
        .status     (status),
        .chg        (chg),
        .high_out   (high_out),
        .period_out (period_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chg === 1'b1) chg_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst    = 1'b1;
        ena    = 1'b1;
        buz_in = 8'h00;
        sel    = 3'd0;
        tick(2);
        rst = 1'b0;
        check("rst_status", 32'(status), 32'h0);
        check("rst_chg", 32'(chg), 32'h0);
        check("rst_high", 32'(high_out), 32'h0);
        check("rst_period", 32'(period_out), 32'h0);
        chg_mark = chg_cnt;
        tick(100);
        check("idle_status", 32'(status), 32'h0);
        check("idle_chg_cnt", 32'(chg_cnt - chg_mark), 32'd0);
        check("idle_period", 32'(period_out), 32'h0);

        // Solid on channel 0
        chg_mark  = chg_cnt;
        buz_in[0] = 1'b1;
        tick(32);
        check("solid_pre", 32'(status[1:0]), 32'h0);
        tick(1);
        check("solid_at", 32'(status[1:0]), 32'h1);
        check("solid_chg_lag", 32'(chg), 32'h0);
        tick(1);
        check("solid_chg", 32'(chg), 32'h1);
        tick(6);
        check("solid_hold", 32'(status), 32'h0001);
        check("solid_chg_cnt", 32'(chg_cnt - chg_mark), 32'd1);
        buz_in[0] = 1'b0;
        tick(40);
        check("solid_off", 32'(status), 32'h0);
        check("solid_off_chg_cnt", 32'(chg_cnt - chg_mark), 32'd2);

        // Pulsed 5/5 on channel 1
        sel       = 3'd1;
        chg_mark  = chg_cnt;
        buz_in[1] = 1'b1; tick(5);
        buz_in[1] = 1'b0; tick(5);
        check("pulse_first", 32'(status[3:2]), 32'h0);
        buz_in[1] = 1'b1; tick(1);
        check("pulse_det", 32'(status[3:2]), 32'h2);
        check("pulse_high", 32'(high_out), 32'd5);
        check("pulse_period", 32'(period_out), 32'd10);
        tick(4);
        buz_in[1] = 1'b0; tick(5);
        repeat (4) begin
            buz_in[1] = 1'b1; tick(5);
            buz_in[1] = 1'b0; tick(5);
        end
        check("pulse_hold", 32'(status), 32'h0008);
        check("pulse_high2", 32'(high_out), 32'd5);
        check("pulse_chg_cnt", 32'(chg_cnt - chg_mark), 32'd1);

        // Pattern ends: OFF after 32 low cycles
        tick(27);
        check("end_pre", 32'(status[3:2]), 32'h2);
        tick(1);
        check("end_off", 32'(status[3:2]), 32'h0);
        check("end_period_kept", 32'(period_out), 32'd10);
        tick(2);
        check("end_chg_cnt", 32'(chg_cnt - chg_mark), 32'd2);

        // All channels together
        chg_mark = chg_cnt;
        buz_in   = 8'hFF;
        tick(32);
        check("multi_pre", 32'(status), 32'h0);
        tick(1);
        check("multi_solid", 32'(status), 32'h5555);
        tick(7);
        check("multi_solid_chg", 32'(chg_cnt - chg_mark), 32'd1);
        check("multi_high_pre", 32'(high_out), 32'd5);
        buz_in = 8'h00;
        tick(1);
        check("multi_high", 32'(high_out), 32'd40);
        tick(31);
        check("multi_off_pre", 32'(status), 32'h5555);
        tick(1);
        check("multi_off", 32'(status), 32'h0);
        tick(2);
        check("multi_off_chg", 32'(chg_cnt - chg_mark), 32'd2);

        // Enable freeze on channel 2
        sel       = 3'd2;
        buz_in[2] = 1'b1; tick(5);
        buz_in[2] = 1'b0; tick(5);
        buz_in[2] = 1'b1; tick(3);
        check("ctl_pulsed", 32'(status[5:4]), 32'h2);
        check("ctl_period", 32'(period_out), 32'd10);
        chg_mark  = chg_cnt;
        ena       = 1'b0;
        buz_in[2] = 1'b0; tick(10);
        buz_in[2] = 1'b1; tick(10);
        check("frz_status", 32'(status), 32'h0020);
        check("frz_high", 32'(high_out), 32'd5);
        check("frz_period", 32'(period_out), 32'd10);
        check("frz_chg_cnt", 32'(chg_cnt - chg_mark), 32'd0);
        ena = 1'b1;
        tick(4);
        buz_in[2] = 1'b0; tick(1);
        check("frz_resume_high", 32'(high_out), 32'd7);
        tick(4);
        buz_in[2] = 1'b1; tick(1);
        check("frz_resume_period", 32'(period_out), 32'd12);
        check("frz_resume_status", 32'(status[5:4]), 32'h2);

        // Reset mid-pattern
        tick(2);
        rst = 1'b1; tick(1);
        rst = 1'b0;
        check("mrst_status", 32'(status), 32'h0);
        check("mrst_high", 32'(high_out), 32'h0);
        check("mrst_period", 32'(period_out), 32'h0);
        check("mrst_chg", 32'(chg), 32'h0);
        tick(5);
        buz_in[2] = 1'b0; tick(5);
        check("mrst_one_rise", 32'(status), 32'h0);
        buz_in[2] = 1'b1; tick(1);
        check("mrst_redetect", 32'(status), 32'h0020);
        check("mrst_high2", 32'(high_out), 32'd5);
        check("mrst_period2", 32'(period_out), 32'd10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/buzzer_pattern_decoder.md
Name: buzzer_pattern_decoder

Overview:
- Monitors the buzzer outputs that the sensor/alarm state machine drives, one line per channel.
- Decodes each line's waveform back into an alarm class: OFF, SOLID or PULSED.
- Measures the high time and period of pulsed channels.
- Used as the readback/self-check path for buzzer drive: status and measured timing are exported for a host or for on-chip comparison against sensor state.

Parameters:
- NCH, 8, number of buzzer channels decoded.
- CNT_W, 8, width of run-length and measurement counters; all counters saturate at 2^CNT_W-1.
- SILENT_CYC, 32, low run length (cycles) at which a channel is declared OFF.
- SOLID_CYC, 32, high run length (cycles) at which a channel is declared SOLID.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  decode enable; when low, all state and counters hold.
- buz_in  in  NCH  buzzer lines, same clock domain, no synchronizer required.
- sel  in  $clog2(NCH)  channel selected for measurement readback.
- status  out  2*NCH  per-channel class, bits [2i+1:2i]: 00 OFF, 01 SOLID, 10 PULSED, 11 unused.
- chg  out  1  one-cycle pulse when any channel's status changes.
- high_out  out  CNT_W  last completed high run length of channel sel.
- period_out  out  CNT_W  last measured period of channel sel (high + low), saturating.

Behaviour:
- Reset (rst=1 on a clock edge):
  - Every channel: s_q=0, run_cnt=0, short_high=0, state OFF, high_len=0, period=0.
  - Outputs: status=0, chg=0, high_out=0, period_out=0.
  - Reset mid-pattern discards any partial measurement.
- ena=0: no register changes except that chg is driven 0. ena=1 enables all rules below.
- Per channel, each enabled edge:
  - s_q <= buz_in[i].
  - Edge condition is buz_in[i] != s_q. On an edge, the completed run length is run_cnt, and run_cnt <= 1.
  - Otherwise run_cnt increments, saturating.
- Falling edge (s_q=1 -> 0):
  - high_len <= completed run.
  - short_high <= (completed run < SOLID_CYC).
- Rising edge (s_q=0 -> 1):
  - Full cycle rule: if short_high=1 and completed low run < SILENT_CYC, then state <= PULSED and period <= high_len + low run (saturating).
  - Otherwise the state is unchanged.
  - In PULSED, every qualifying rising edge refreshes period.
- Timeouts, checked on non-edge cycles:
  - s_q=0 and run_cnt==SILENT_CYC: state <= OFF, short_high <= 0.
  - s_q=1 and run_cnt==SOLID_CYC: state <= SOLID, short_high <= 0.
  - Timeouts fire only once per run because the compare is equality; the saturated counter does not retrigger.
- Latency:
  - A level held from the first sampling edge is declared after that edge plus SILENT_CYC / SOLID_CYC further edges.
  - PULSED is declared on the edge that samples the second rising transition.
- status is the registered per-channel state.
- chg is registered: 1 on the cycle after any status bit changed, otherwise 0.
- high_out and period_out are combinational muxes of the registered values of channel sel. Changing sel takes effect the same cycle.
- All channels are independent. Simultaneous edges or timeouts on different channels are all processed in the same cycle, and produce a single chg pulse.

Decomposition:
- Package buzdec_pkg:
  - status enum (OFF=2'b00, SOLID=2'b01, PULSED=2'b10).
  - Default threshold constants.
- Sub-module buzzer_chan_decoder, instantiated NCH times:
  - Holds s_q, run_cnt, short_high, state, high_len and period.
  - Outputs state and a change flag.
- Top level: generate loop, chg OR-reduction register, sel readback mux.

Test Plan:
- Reset / idle: rst high 2 cycles, buz_in=0 -> status=16'h0000, chg=0, high_out=0, period_out=0; stays so for 100 cycles.
- Solid: buz_in[0] held 1 for 40 cycles -> status[1:0]=01 exactly 33 edges after first sampling edge; chg pulses once; no PULSED.
- Pulsed: buz_in[1] toggles 5 high / 5 low, 6 periods, sel=1 -> status[3:2]=10 after second rising edge; high_out=5, period_out=10; chg single pulse.
- Pattern ends: continue previous, then buz_in[1]=0 -> status[3:2]=00 after 32 low cycles; chg pulses; period_out retains 10.
- Multi-channel: buz_in=8'hFF for 40 cycles, then 8'h00 for 40 cycles -> all channels SOLID simultaneously (status=16'h5555), one chg pulse; then all OFF together, one chg pulse.
- Control: during a 5/5 pulse, ena=0 for 20 cycles -> status and counters frozen, no chg. Then rst mid-pattern -> status=0, high_out=0 next cycle, and re-detection of PULSED requires two fresh rising edges.
